// File: rtl/line_refill_unit.sv
// line_refill_unit: instruction-cache miss back end. Reads one line word by word
// over a valid/ready memory port and hands the assembled line to the cache.
module line_refill_unit #(
    parameter int LINE_BYTES = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    MissValid,
    input  logic [ADDR_WIDTH-1:0]   MissAddress,
    output logic                    MissReady,
    output logic                    MemReqValid,
    output logic [ADDR_WIDTH-1:0]   MemReqAddress,
    input  logic                    MemReqReady,
    input  logic                    MemRespValid,
    input  logic [31:0]             MemRespData,
    input  logic                    MemRespError,
    output logic                    FillValid,
    output logic [ADDR_WIDTH-1:0]   FillAddress,
    output logic [LINE_BYTES*8-1:0] FillData,
    output logic                    FillError,
    input  logic                    FillReady
);

    // state   | meaning
    // IDLE    | no miss in flight; MissReady high
    // FETCH   | issuing word reads and collecting responses in order
    // DELIVER | line complete; FillValid held until FillReady

    localparam int BEATS        = LINE_BYTES / 4;
    localparam int OFFSET_WIDTH = $clog2(LINE_BYTES);
    localparam int CNT_W        = $clog2(BEATS) + 1;
    localparam int IDX_W        = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]      BEATS_CNT   = CNT_W'(BEATS);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_WIDTH) - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP   = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       req_cnt;
    logic [CNT_W-1:0]       resp_cnt;
    logic [IDX_W-1:0]       resp_idx;
    logic [ADDR_WIDTH-1:0]  miss_base;
    logic                   req_fire;
    logic                   resp_take;
    logic                   last_req;
    logic                   last_resp;

    assign miss_base = MissAddress & ~OFFSET_MASK;
    assign req_fire  = MemReqValid && MemReqReady;
    assign resp_take = MemRespValid && (resp_cnt != BEATS_CNT);
    assign last_req  = (req_cnt == LAST_BEAT);
    assign last_resp = (resp_cnt == LAST_BEAT);
    assign resp_idx  = resp_cnt[IDX_W-1:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= IDLE;
            MissReady     <= 1'b1;
            MemReqValid   <= 1'b0;
            MemReqAddress <= '0;
            FillValid     <= 1'b0;
            FillAddress   <= '0;
            FillData      <= '0;
            FillError     <= 1'b0;
            req_cnt       <= '0;
            resp_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MissValid) begin
                        state         <= FETCH;
                        MissReady     <= 1'b0;
                        MemReqValid   <= 1'b1;
                        MemReqAddress <= miss_base;
                        FillAddress   <= miss_base;
                        FillError     <= 1'b0;
                        req_cnt       <= '0;
                        resp_cnt      <= '0;
                    end
                end

                FETCH: begin
                    // request and response sides advance independently
                    if (req_fire) begin
                        req_cnt       <= req_cnt + CNT_W'(1);
                        MemReqAddress <= MemReqAddress + WORD_STEP;
                        if (last_req) begin
                            MemReqValid <= 1'b0;
                        end
                    end
                    if (resp_take) begin
                        FillData[32*resp_idx +: 32] <= MemRespData;
                        resp_cnt  <= resp_cnt + CNT_W'(1);
                        FillError <= FillError | MemRespError;
                        if (last_resp) begin
                            state       <= DELIVER;
                            FillValid   <= 1'b1;
                            MemReqValid <= 1'b0;
                        end
                    end
                end

                DELIVER: begin
                    if (FillReady) begin
                        state     <= IDLE;
                        FillValid <= 1'b0;
                        MissReady <= 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    MissReady   <= 1'b1;
                    MemReqValid <= 1'b0;
                    FillValid   <= 1'b0;
                end
            endcase
        end
    end

endmodule
